// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring decoder.
// The vector helpers work on a wide bus and take the live ring width as an argument.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT,
        TRACK,
        LOCKED
    } state_e;

    localparam int unsigned RING_WIDTH = 4;
    localparam int unsigned IDX_W      = $clog2(RING_WIDTH);
    localparam int unsigned MAX_W      = 64;

    // Bit 0 wraps into position width-1; callers truncate back to their width.
    function automatic logic [MAX_W-1:0] ror1(input logic [MAX_W-1:0] vec,
                                              input int unsigned     width);
        logic [MAX_W-1:0] wrap_bit;
        wrap_bit = vec[0] ? (MAX_W'(1) << (width - 1)) : '0;
        return (vec >> 1) | wrap_bit;
    endfunction

    function automatic logic is_onehot(input logic [MAX_W-1:0] vec);
        return $countones(vec) == 1;
    endfunction

endpackage

// File: rtl/ring_decoder_onehot_to_bin.sv
// Combinational one-hot to binary encoder.
// Output is meaningless for non-one-hot input; the parent only uses it on valid samples.
module onehot_to_bin #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot_i,
    output logic [IDX_W-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_i[i]) begin
                bin_o = bin_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_decoder.sv
// Receive side of a one-hot ring counter: decodes the active position, locks onto
// a right-rotating sequence, counts laps and flags sequence errors while locked.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH      = RING_WIDTH,
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     sample_en,
    output logic [$clog2(WIDTH)-1:0] index_out,
    output logic                     onehot_ok,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [CNT_W-1:0]         lap_count,
    output logic [CNT_W-1:0]         err_count
);

    localparam int IW = $clog2(WIDTH);
    localparam int SW = $clog2(LOCK_COUNT + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [SW-1:0]    step_q, step_d;
    logic [IW-1:0]    index_q, index_d;
    logic             ok_q, ok_d;
    logic             locked_q, locked_d;
    logic             errp_q, errp_d;
    logic [CNT_W-1:0] lap_q, lap_d;
    logic [CNT_W-1:0] errc_q, errc_d;

    logic [IW-1:0]    enc_idx;
    logic [WIDTH-1:0] expect_vec;
    logic             valid;
    logic             correct;
    logic [SW-1:0]    step_inc;

    onehot_to_bin #(.WIDTH(WIDTH)) u_enc (
        .onehot_i (ring_in),
        .bin_o    (enc_idx)
    );

    assign expect_vec = WIDTH'(ror1(MAX_W'(prev_q), WIDTH));
    assign valid      = is_onehot(MAX_W'(ring_in));
    assign correct    = valid && (ring_in == expect_vec);
    assign step_inc   = step_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        step_d   = step_q;
        index_d  = index_q;
        ok_d     = ok_q;
        locked_d = locked_q;
        errp_d   = 1'b0;
        lap_d    = lap_q;
        errc_d   = errc_q;

        if (sample_en) begin
            ok_d = valid;
            if (valid) begin
                index_d = enc_idx;
            end

            unique case (state_q)
                HUNT: begin
                    if (valid) begin
                        prev_d  = ring_in;
                        step_d  = '0;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (correct) begin
                        prev_d = ring_in;
                        step_d = step_inc;
                        if (step_inc == SW'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (valid) begin
                        prev_d = ring_in;
                        step_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (correct) begin
                        prev_d = ring_in;
                        // Landing on the MSB means the ring just wrapped past bit 0.
                        if (ring_in[WIDTH-1]) begin
                            lap_d = lap_q + 1'b1;
                        end
                    end else begin
                        errp_d   = 1'b1;
                        locked_d = 1'b0;
                        if (errc_q != '1) begin
                            errc_d = errc_q + 1'b1;
                        end
                        if (valid) begin
                            prev_d  = ring_in;
                            step_d  = '0;
                            state_d = TRACK;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            step_q   <= '0;
            index_q  <= '0;
            ok_q     <= 1'b0;
            locked_q <= 1'b0;
            errp_q   <= 1'b0;
            lap_q    <= '0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            index_q  <= index_d;
            ok_q     <= ok_d;
            locked_q <= locked_d;
            errp_q   <= errp_d;
            lap_q    <= lap_d;
            errc_q   <= errc_d;
        end
    end

    assign index_out = index_q;
    assign onehot_ok = ok_q;
    assign locked    = locked_q;
    assign err_pulse = errp_q;
    assign lap_count = lap_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder: directed scenarios plus a random phase,
// all compared against a position-based reference model of the ring protocol.
module tb_ring_decoder;
    import ring_pkg::*;

    localparam int W  = 4;
    localparam int LC = 2;
    localparam int CW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [W-1:0]       ring_in;
    logic               sample_en;
    logic [IDX_W-1:0]   index_out;
    logic               onehot_ok;
    logic               locked;
    logic               err_pulse;
    logic [CW-1:0]      lap_count;
    logic [CW-1:0]      err_count;

    int checks = 0;
    int passes = 0;

    // Reference model: mode 0=hunting, 1=tracking, 2=locked; positions as integers.
    int mMode, mPos, mRun, mIndex, mOk, mLocked, mErrPulse, mLap, mErr;

    ring_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ring_in   (ring_in),
        .sample_en (sample_en),
        .index_out (index_out),
        .onehot_ok (onehot_ok),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lap_count (lap_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mMode = 0; mPos = 0; mRun = 0; mIndex = 0; mOk = 0;
        mLocked = 0; mErrPulse = 0; mLap = 0; mErr = 0;
    endtask

    task automatic modelStep(input logic en, input logic [W-1:0] v);
        int ones, pos;
        logic good;
        mErrPulse = 0;
        if (!en) return;
        ones = 0; pos = 0;
        for (int i = 0; i < W; i++) if (v[i]) begin ones++; pos = i; end
        mOk = (ones == 1);
        if (mOk) mIndex = pos;
        good = mOk && (pos == (mPos + W - 1) % W);
        if (mMode == 0) begin
            if (mOk) begin mMode = 1; mPos = pos; mRun = 0; end
        end else if (mMode == 1) begin
            if (good) begin
                mPos = pos; mRun++;
                if (mRun == LC) mMode = 2;
            end else if (mOk) begin
                mPos = pos; mRun = 0;
            end else mMode = 0;
        end else begin
            if (good) begin
                mPos = pos;
                if (pos == W - 1) mLap = (mLap + 1) % (1 << CW);
            end else begin
                mErrPulse = 1;
                if (mErr < (1 << CW) - 1) mErr++;
                if (mOk) begin mMode = 1; mPos = pos; mRun = 0; end
                else mMode = 0;
            end
        end
        mLocked = (mMode == 2);
    endtask

    function automatic logic [W-1:0] nextVec();
        return W'(1) << ((mPos + W - 1) % W);
    endfunction

    task automatic applyStimulus(input logic en, input logic [W-1:0] v);
        sample_en = en;
        ring_in   = v;
        @(posedge clk);
        #1;
        modelStep(en, v);
    endtask

    task automatic doReset();
        reset = 1'b1; sample_en = 1'b0; ring_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({index_out, onehot_ok, locked, err_pulse, lap_count, err_count} !== '0)
            $display("[TB] FAIL reset_state: got %0h expected 0",
                     {index_out, onehot_ok, locked, err_pulse, lap_count, err_count});
        else passes++;
    endtask

    task automatic test_lock_and_laps();
        logic [W-1:0] seq [6];
        int           idx [6];
        seq = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        idx = '{0, 3, 2, 1, 0, 3};
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, seq[k]);
            checks++;
            if (int'(index_out) !== idx[k] || int'(index_out) !== mIndex)
                $display("[TB] FAIL lap_index[%0d]: got %0d expected %0d", k, index_out, idx[k]);
            else passes++;
            checks++;
            if (int'(locked) !== mLocked || (k == 2 && locked !== 1'b1))
                $display("[TB] FAIL lap_locked[%0d]: got %0b expected %0d", k, locked, mLocked);
            else passes++;
            checks++;
            if (int'(lap_count) !== mLap || err_pulse !== 1'b0)
                $display("[TB] FAIL lap_count[%0d]: got %0d/%0b expected %0d/0", k, lap_count, err_pulse, mLap);
            else passes++;
        end
        checks++;
        if (lap_count !== 8'd1)
            $display("[TB] FAIL lap_final: got %0d expected 1", lap_count);
        else passes++;
    endtask

    task automatic test_corrupt();
        applyStimulus(1'b1, 4'b0011);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 ||
            onehot_ok !== 1'b0 || index_out !== 2'd3)
            $display("[TB] FAIL corrupt: got p%0b e%0d l%0b o%0b i%0d expected p1 e1 l0 o0 i3",
                     err_pulse, err_count, locked, onehot_ok, index_out);
        else passes++;
        applyStimulus(1'b1, 4'b0100);
        checks++;
        if (err_pulse !== 1'b0 || locked !== 1'b0)
            $display("[TB] FAIL corrupt_pulse_width: got p%0b l%0b expected p0 l0", err_pulse, locked);
        else passes++;
        applyStimulus(1'b1, 4'b0010);
        applyStimulus(1'b1, 4'b0001);
        checks++;
        if (locked !== 1'b1 || int'(locked) !== mLocked)
            $display("[TB] FAIL corrupt_relock: got %0b expected 1", locked);
        else passes++;
    endtask

    task automatic test_wrong_dir();
        applyStimulus(1'b1, 4'b0010);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0 || index_out !== 2'd1)
            $display("[TB] FAIL wrong_dir: got p%0b e%0d l%0b i%0d expected p1 e2 l0 i1",
                     err_pulse, err_count, locked, index_out);
        else passes++;
        applyStimulus(1'b1, 4'b0001);
        applyStimulus(1'b1, 4'b1000);
        checks++;
        if (locked !== 1'b1 || lap_count !== 8'd1)
            $display("[TB] FAIL wrong_dir_track: got l%0b lap%0d expected l1 lap1", locked, lap_count);
        else passes++;
    endtask

    task automatic test_idle_gating();
        logic [IDX_W-1:0] hIdx;
        logic [CW-1:0]    hLap, hErr;
        logic             hOk, hLock;
        doReset();
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 4'b0000);
        checks++;
        if (locked !== 1'b0 || err_count !== 8'd0 || onehot_ok !== 1'b0)
            $display("[TB] FAIL idle_hunt: got l%0b e%0d o%0b expected l0 e0 o0", locked, err_count, onehot_ok);
        else passes++;
        applyStimulus(1'b1, 4'b0010);
        applyStimulus(1'b1, 4'b0001);
        applyStimulus(1'b1, 4'b1000);
        applyStimulus(1'b1, 4'b0100);
        applyStimulus(1'b1, 4'b0110);
        hIdx = index_out; hLap = lap_count; hErr = err_count; hOk = onehot_ok; hLock = locked;
        checks++;
        if (err_pulse !== 1'b1 || int'(err_count) !== mErr)
            $display("[TB] FAIL gate_setup: got p%0b e%0d expected p1 e%0d", err_pulse, err_count, mErr);
        else passes++;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, W'($urandom));
            checks++;
            if (err_pulse !== 1'b0 || index_out !== hIdx || lap_count !== hLap ||
                err_count !== hErr || onehot_ok !== hOk || locked !== hLock)
                $display("[TB] FAIL gate_hold[%0d]: got p%0b i%0d lap%0d e%0d o%0b l%0b expected p0 i%0d lap%0d e%0d o%0b l%0b",
                         k, err_pulse, index_out, lap_count, err_count, onehot_ok, locked,
                         hIdx, hLap, hErr, hOk, hLock);
            else passes++;
        end
    endtask

    task automatic test_saturation();
        int bad = 0;
        doReset();
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b1, 4'b0001);
            applyStimulus(1'b1, 4'b1000);
            applyStimulus(1'b1, 4'b0100);
            applyStimulus(1'b1, 4'b0000);
            if (int'(err_count) !== mErr) bad++;
        end
        checks++;
        if (bad != 0)
            $display("[TB] FAIL sat_track: got %0d wrong steps expected 0", bad);
        else passes++;
        checks++;
        if (err_count !== 8'd255)
            $display("[TB] FAIL sat_final: got %0d expected 255", err_count);
        else passes++;
    endtask

    task automatic test_reset_priority();
        doReset();
        applyStimulus(1'b1, 4'b0001);
        for (int k = 0; k < 40 && mLap < 5; k++) applyStimulus(1'b1, nextVec());
        checks++;
        if (lap_count !== 8'd5 || locked !== 1'b1)
            $display("[TB] FAIL rstp_setup: got lap%0d l%0b expected lap5 l1", lap_count, locked);
        else passes++;
        reset = 1'b1; sample_en = 1'b1; ring_in = nextVec();
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        checks++;
        if ({index_out, onehot_ok, locked, err_pulse, lap_count, err_count} !== '0)
            $display("[TB] FAIL rstp_outputs: got %0h expected 0",
                     {index_out, onehot_ok, locked, err_pulse, lap_count, err_count});
        else passes++;
        applyStimulus(1'b1, 4'b0100);
        applyStimulus(1'b1, 4'b0010);
        checks++;
        if (locked !== 1'b0 || index_out !== 2'd1)
            $display("[TB] FAIL rstp_hunt: got l%0b i%0d expected l0 i1", locked, index_out);
        else passes++;
    endtask

    task automatic test_random();
        int bad = 0;
        logic [W-1:0] v;
        logic en;
        doReset();
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 99) < 85);
            v  = ($urandom_range(0, 99) < 70) ? nextVec() : W'($urandom);
            applyStimulus(en, v);
            checks++;
            if (int'(index_out) !== mIndex || int'(onehot_ok) !== mOk ||
                int'(locked) !== mLocked || int'(err_pulse) !== mErrPulse ||
                int'(lap_count) !== mLap || int'(err_count) !== mErr) begin
                if (bad < 5)
                    $display("[TB] FAIL random[%0d]: got i%0d o%0b l%0b p%0b lap%0d e%0d expected i%0d o%0d l%0d p%0d lap%0d e%0d",
                             k, index_out, onehot_ok, locked, err_pulse, lap_count, err_count,
                             mIndex, mOk, mLocked, mErrPulse, mLap, mErr);
                bad++;
            end else passes++;
        end
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; ring_in = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lock_and_laps();
        test_corrupt();
        test_wrong_dir();
        test_idle_gating();
        test_saturation();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
